data_path: RTL and testbench

Single-cycle 16-bit processor datapath: instruction ROM, 8×16 register file, ALU and 32×16 data memory, in one block. Control signals arrive from an external control unit. The instruction address `pcFill` is supplied externally, so the block contains no PC register. Every internal decode and datapath node is brought out as a port for debug and verification.

---
 rtl/data_path_pkg.sv | 32 +++
 rtl/data_path_register_file.sv | 33 +++
 rtl/data_path.sv | 82 ++++++++
 tb/tb_data_path.sv | 122 ++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// data_path_pkg: shared opcode/funct/width constants, ALU op type and the fixed instruction ROM.
package data_path_pkg;
   localparam int DATA_W = 16;
   localparam int REG_W  = 3;
   localparam logic [1:0] OP_R    = 2'b00;
   localparam logic [1:0] OP_ADDI = 2'b01;
   localparam logic [1:0] OP_LW   = 2'b10;
   localparam logic [1:0] OP_SW   = 2'b11;
   localparam logic [1:0] F_ADD = 2'b00;
   localparam logic [1:0] F_SUB = 2'b01;
   localparam logic [1:0] F_SLL = 2'b10;
   localparam logic [1:0] F_AND = 2'b11;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_AND} alu_op_e;

   function automatic alu_op_e alu_ctrl(input logic alu_op_in, input logic [1:0] op, input logic [1:0] funct);
      if (!alu_op_in || op != OP_R) return ALU_ADD;
      return funct == F_SUB ? ALU_SUB :
             funct == F_SLL ? ALU_SLL :
             funct == F_AND ? ALU_AND : ALU_ADD;
   endfunction

   // Unlisted words read 0, which decodes as add r0,r0,r0.
   function automatic logic [DATA_W-1:0] rom_word(input logic [5:0] addr);
      return addr == 6'd11 ? 16'h5105 :
             addr == 6'd12 ? 16'h8B04 :
             addr == 6'd13 ? 16'h19A1 :
             addr == 6'd14 ? 16'h2BC0 :
             addr == 6'd15 ? 16'h30EA :
             addr == 6'd16 ? 16'hC703 : 16'h0000;
   endfunction
endpackage

// File: rtl/data_path_register_file.sv
// register_file: 8x16 registers, two async read ports, one sync write port, r0 hardwired to zero.
module register_file
   import data_path_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  ra1,
   input  logic [REG_W-1:0]  ra2,
   input  logic [REG_W-1:0]  wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              we,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);
   logic [DATA_W-1:0] regs_q [8];
   logic [DATA_W-1:0] regs_d [8];

   always_comb begin
      regs_d = regs_q;
      if (we && wa != '0) regs_d[wa] = wd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= DATA_W'(i);
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd1 = ra1 == '0 ? '0 : regs_q[ra1];
   assign rd2 = ra2 == '0 ? '0 : regs_q[ra2];
endmodule

// File: rtl/data_path.sv
// data_path: single-cycle 16-bit datapath (ROM, register file, ALU, 32-word data memory);
// control comes from outside and every internal node is exposed as a port.
module data_path
   import data_path_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       pcFill,
   input  logic              RegDst,
   input  logic              ALUSrc,
   input  logic              MemToReg,
   input  logic              RegWrite,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              ALUOp,
   output logic [1:0]        opcode,
   output logic [REG_W-1:0]  RS,
   output logic [REG_W-1:0]  RT,
   output logic [REG_W-1:0]  RD,
   output logic [REG_W-1:0]  daljaMux,
   output logic [DATA_W-1:0] immidiate_long,
   output logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic [DATA_W-1:0] VLERA,
   output logic [DATA_W-1:0] REZULTATI,
   output logic [DATA_W-1:0] ReadData
);
   logic [DATA_W-1:0] instr;
   logic [2:0]        shamt;
   alu_op_e           alu_op;
   logic [DATA_W-1:0] dmem_q [32];
   logic [DATA_W-1:0] dmem_d [32];
   logic              unused_hi;

   assign instr          = rom_word(pcFill[5:0]);
   assign opcode         = instr[15:14];
   assign RS             = instr[13:11];
   assign RT             = instr[10:8];
   assign RD             = instr[7:5];
   assign shamt          = instr[4:2];
   assign immidiate_long = {{8{instr[7]}}, instr[7:0]};
   assign daljaMux       = RegDst ? RD : RT;
   assign VLERA          = ALUSrc ? immidiate_long : RD2;
   assign alu_op         = alu_ctrl(ALUOp, opcode, instr[1:0]);
   assign unused_hi      = ^{pcFill[15:6], REZULTATI[15:5]};

   always_comb begin
      REZULTATI = alu_op == ALU_SUB ? RD1 - VLERA :
                  alu_op == ALU_SLL ? RD1 << shamt :
                  alu_op == ALU_AND ? RD1 & VLERA : RD1 + VLERA;
   end

   // Only the low five result bits address memory, so addresses wrap at 32.
   assign ReadData  = MemRead ? dmem_q[REZULTATI[4:0]] : '0;
   assign WriteData = MemToReg ? ReadData : REZULTATI;

   always_comb begin
      dmem_d = dmem_q;
      if (MemWrite) dmem_d[REZULTATI[4:0]] = RD2;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) dmem_q[i] <= DATA_W'(i);
      end else begin
         dmem_q <= dmem_d;
      end
   end

   register_file u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1   (RS),
      .ra2   (RT),
      .wa    (daljaMux),
      .wd    (WriteData),
      .we    (RegWrite),
      .rd1   (RD1),
      .rd2   (RD2)
   );
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed program walk through the ROM with hand-computed expectations.
module tb_data_path;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pcFill;
   logic        RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp;
   logic [1:0]  opcode;
   logic [2:0]  RS, RT, RD, daljaMux;
   logic [15:0] immidiate_long, WriteData, RD1, RD2, VLERA, REZULTATI, ReadData;
   int          n_vec = 0;
   int          n_bad = 0;

   // control word: {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp}
   localparam logic [6:0] C_ADDI = 7'b0101001;
   localparam logic [6:0] C_LW   = 7'b0111100;
   localparam logic [6:0] C_R    = 7'b1001001;
   localparam logic [6:0] C_SW   = 7'b0100011;
   localparam logic [6:0] C_RDM  = 7'b0100101;

   data_path dut (
      .clk(clk), .reset(reset), .pcFill(pcFill),
      .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
      .opcode(opcode), .RS(RS), .RT(RT), .RD(RD), .daljaMux(daljaMux),
      .immidiate_long(immidiate_long), .WriteData(WriteData), .RD1(RD1), .RD2(RD2),
      .VLERA(VLERA), .REZULTATI(REZULTATI), .ReadData(ReadData)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic apply(input logic [15:0] pc, input logic [6:0] c);
      @(negedge clk);
      pcFill = pc;
      {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp} = c;
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      pcFill = 16'd11;
      {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp} = 7'b0;
      #1;
      chk("rst_r2", RD1, 16'd2);
      chk("rst_r1", RD2, 16'd1);
      chk("rst_add", REZULTATI, 16'd3);
      @(negedge clk);
      reset = 1'b0;

      apply(16'd11, C_ADDI);
      chk("addi_op", {14'd0, opcode}, 16'd1);
      chk("addi_rs", {13'd0, RS}, 16'd2);
      chk("addi_rt", {13'd0, RT}, 16'd1);
      chk("addi_imm", immidiate_long, 16'd5);
      chk("addi_res", REZULTATI, 16'd7);
      chk("addi_dst", {13'd0, daljaMux}, 16'd1);

      apply(16'd12, C_LW);
      chk("r1_after_addi", RD1, 16'd7);
      chk("lw_res", REZULTATI, 16'd11);
      chk("lw_rdata", ReadData, 16'd11);
      chk("lw_dst", {13'd0, daljaMux}, 16'd3);
      chk("lw_wdata", WriteData, 16'd11);

      apply(16'd13, C_R);
      chk("sub_rd1", RD1, 16'd11);
      chk("sub_rd2", RD2, 16'd7);
      chk("sub_res", REZULTATI, 16'd4);
      chk("sub_dst", {13'd0, daljaMux}, 16'd5);

      apply(16'd14, C_R);
      chk("add_rd1", RD1, 16'd4);
      chk("add_res", REZULTATI, 16'd15);
      chk("add_dst", {13'd0, daljaMux}, 16'd6);

      apply(16'd15, C_R);
      chk("r6", RD1, 16'd15);
      chk("sll_res", REZULTATI, 16'd60);

      apply(16'd16, C_SW);
      chk("r7", RD2, 16'd60);
      chk("sw_res", REZULTATI, 16'd3);
      chk("sw_vlera", VLERA, 16'd3);

      apply(16'd16, C_RDM);
      chk("dmem3", ReadData, 16'd60);
      chk("r7_kept", RD2, 16'd60);

      apply(16'h004B, 7'b0100001);
      chk("alias_op", {14'd0, opcode}, 16'd1);
      chk("alias_res", REZULTATI, 16'd7);

      apply(16'd0, 7'b0001001);
      chk("nop_res", REZULTATI, 16'd0);
      chk("nop_rdata", ReadData, 16'd0);

      apply(16'd11, 7'b1101001);
      chk("r0_dst", {13'd0, daljaMux}, 16'd0);
      chk("r0_wdata", WriteData, 16'd7);

      apply(16'd16, C_RDM);
      chk("r0_zero", RD1, 16'd0);
      chk("dmem3_again", ReadData, 16'd60);

      #1 reset = 1'b1;
      #1;
      chk("rst_r7", RD2, 16'd7);
      chk("rst_dmem3", ReadData, 16'd3);
      @(negedge clk);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
